// File: rtl/ethii_tx_arbiter_if.sv
// Header + AXI-Stream payload bundle for one or more Ethernet-II TX clients.
// N lanes side by side; lane i sits at [48*i+:48] / [DATA_W*i+:DATA_W].
interface ethii_tx_arbiter_if #(
   parameter int N      = 1,
   parameter int DATA_W = 32
);
   localparam int KEEP_W = DATA_W / 8;

   logic [N*48-1:0]     hdr_dest;
   logic [N*48-1:0]     hdr_src;
   logic [N-1:0]        hdr_vld;
   logic [N-1:0]        hdr_rdy;
   logic [N*DATA_W-1:0] tdata;
   logic [N*KEEP_W-1:0] tkeep;
   logic [N-1:0]        tvld;
   logic [N-1:0]        tlast;
   logic [N-1:0]        trdy;

   modport master (
      output hdr_dest, hdr_src, hdr_vld,
      output tdata, tkeep, tvld, tlast,
      input  hdr_rdy, trdy
   );

   modport slave (
      input  hdr_dest, hdr_src, hdr_vld,
      input  tdata, tkeep, tvld, tlast,
      output hdr_rdy, trdy
   );
endinterface

// File: rtl/ethii_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one Ethernet-II packer
// among N_SRC clients; header and payload are muxed combinationally.
module ethii_tx_arbiter #(
   parameter int N_SRC  = 2,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   ethii_tx_arbiter_if.slave  s,
   ethii_tx_arbiter_if.master m,
   output logic [N_SRC-1:0]   grant_o
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int PW     = $clog2(N_SRC);

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state, state_nxt;
   logic [N_SRC-1:0] grant_nxt;
   logic [PW-1:0]    rr_ptr, rr_nxt;
   logic             hdr_done, hdr_done_nxt;
   logic [PW-1:0]    pick, cand;
   logic             found;
   logic             hdr_hs, last_hs, frame_end;

   function automatic logic [PW-1:0] wrap(input int v);
      return PW'(v % N_SRC);
   endfunction

   // First header requester at or after rr_ptr, cyclically.
   always_comb begin : pick_c
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         cand = wrap(int'(rr_ptr) + k);
         if (s.hdr_vld[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin : mux_c
      m.hdr_dest = '0;
      m.hdr_src  = '0;
      m.hdr_vld  = 1'b0;
      m.tdata    = '0;
      m.tkeep    = '0;
      m.tvld     = 1'b0;
      m.tlast    = 1'b0;
      s.hdr_rdy  = '0;
      s.trdy     = '0;
      if (state == XFER) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (grant_o[i]) begin
               m.hdr_dest   = s.hdr_dest[48*i +: 48];
               m.hdr_src    = s.hdr_src[48*i +: 48];
               m.hdr_vld    = s.hdr_vld[i] & ~hdr_done;
               m.tdata      = s.tdata[DATA_W*i +: DATA_W];
               m.tkeep      = s.tkeep[KEEP_W*i +: KEEP_W];
               m.tvld       = s.tvld[i];
               m.tlast      = s.tlast[i];
               s.hdr_rdy[i] = m.hdr_rdy & ~hdr_done;
               s.trdy[i]    = m.trdy;
            end
         end
      end
   end

   assign hdr_hs    = m.hdr_vld & m.hdr_rdy;
   assign last_hs   = m.tvld & m.trdy & m.tlast;
   // Header and tlast may complete in either order or together.
   assign frame_end = (hdr_done | hdr_hs) & last_hs;

   always_comb begin : fsm_c
      state_nxt    = state;
      grant_nxt    = grant_o;
      rr_nxt       = rr_ptr;
      hdr_done_nxt = hdr_done;
      unique case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = XFER;
               grant_nxt    = N_SRC'(1) << pick;
               hdr_done_nxt = 1'b0;
            end
         end
         XFER: begin
            if (hdr_hs) hdr_done_nxt = 1'b1;
            if (frame_end) begin
               state_nxt    = IDLE;
               grant_nxt    = '0;
               hdr_done_nxt = 1'b0;
               for (int i = 0; i < N_SRC; i++) begin
                  if (grant_o[i]) rr_nxt = wrap(i + 1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant_o  <= '0;
         rr_ptr   <= '0;
         hdr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant_o  <= grant_nxt;
         rr_ptr   <= rr_nxt;
         hdr_done <= hdr_done_nxt;
      end
   end
endmodule

// File: tb/tb_ethii_tx_arbiter.sv
// Scoreboard bench for ethii_tx_arbiter: random two-client traffic
// against a frame-level round-robin model.
module tb_ethii_tx_arbiter;
   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] grant;

   ethii_tx_arbiter_if #(.N(2), .DATA_W(32)) s_if ();
   ethii_tx_arbiter_if #(.N(1), .DATA_W(32)) m_if ();

   ethii_tx_arbiter #(.N_SRC(2), .DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .s       (s_if),
      .m       (m_if),
      .grant_o (grant)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [95:0] hq0[$], hq1[$];
   word_t       wq0[$], wq1[$];
   logic [1:0]  glog[$];

   // client driver state
   int          nfr[2], widx[2], wlen[2], gap[2];
   bit          busy[2], hdr_out[2];
   logic [31:0] fdata[2][16];
   logic [3:0]  fkeep[2][16];
   logic [47:0] fdest[2], fsrc[2];
   int          hv_cnt;

   // traffic knobs
   int         len_min, len_max, gap_max;
   int         tv_pct, trdy_pct, hdr_delay;
   bit         eager;
   logic [3:0] keep_last;

   task automatic chk(input string name,
                      input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- monitor / reference model ----------------
   bit mbusy, mseen, mnew;
   int mowner, mrr;

   always @(negedge clk) begin : monitor
      logic        hs;
      logic [95:0] eh;
      word_t       ew;
      if (!rst_n) begin
         mbusy = 0; mseen = 0; mnew = 0; mrr = 0;
         chk("rst grant", grant, 0);
         chk("rst m_hdr_vld", m_if.hdr_vld, 0);
         chk("rst m_tvld", m_if.tvld, 0);
         chk("rst s_hdr_rdy", s_if.hdr_rdy, 0);
         chk("rst s_trdy", s_if.trdy, 0);
      end else begin
         if (mnew) begin
            glog.push_back(grant);
            mnew = 0;
         end
         chk("grant", grant, mbusy ? 2'(1 << mowner) : 2'b0);
         if (mbusy) begin
            hs = m_if.hdr_vld & m_if.hdr_rdy;
            chk("m_hdr_vld", m_if.hdr_vld,
                s_if.hdr_vld[mowner] & ~mseen);
            chk("m_tvld", m_if.tvld, s_if.tvld[mowner]);
            chk("idle client rdy",
                {s_if.hdr_rdy[1-mowner], s_if.trdy[1-mowner]}, 0);
            if (hs) begin
               if ((mowner == 0 ? hq0.size() : hq1.size()) == 0) begin
                  chk("extra header", 1, 0);
               end else begin
                  eh = (mowner == 0) ? hq0.pop_front() : hq1.pop_front();
                  chk("header", {m_if.hdr_dest, m_if.hdr_src}, eh);
               end
            end
            if (m_if.tvld && m_if.trdy) begin
               if ((mowner == 0 ? wq0.size() : wq1.size()) == 0) begin
                  chk("extra word", 1, 0);
               end else begin
                  ew = (mowner == 0) ? wq0.pop_front() : wq1.pop_front();
                  chk("word", {m_if.tdata, m_if.tkeep, m_if.tlast}, ew);
               end
               if (m_if.tlast && (mseen || hs)) begin
                  mbusy = 0;
                  mrr   = (mowner + 1) % 2;
               end
            end
            if (hs) mseen = 1;
         end else begin
            chk("idle outputs", {m_if.hdr_vld, m_if.tvld}, 0);
            if (|s_if.hdr_vld) begin
               mowner = s_if.hdr_vld[mrr] ? mrr : 1 - mrr;
               mbusy  = 1;
               mseen  = 0;
               mnew   = 1;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive();
      bit tv;
      for (int c = 0; c < 2; c++) begin
         tv = busy[c] && widx[c] < wlen[c] &&
              (eager || !hdr_out[c] || widx[c] != wlen[c] - 1) &&
              ($urandom_range(99) < tv_pct);
         s_if.hdr_dest[48*c +: 48] = fdest[c];
         s_if.hdr_src[48*c +: 48]  = fsrc[c];
         s_if.hdr_vld[c]           = busy[c] && hdr_out[c];
         s_if.tvld[c]              = tv;
         s_if.tdata[32*c +: 32]    = fdata[c][widx[c]];
         s_if.tkeep[4*c +: 4]      = fkeep[c][widx[c]];
         s_if.tlast[c]             = busy[c] && widx[c] == wlen[c] - 1;
      end
      m_if.trdy    = ($urandom_range(99) < trdy_pct);
      m_if.hdr_rdy = (hdr_delay == 0) || (hv_cnt >= hdr_delay);
   endtask

   task automatic new_frame(input int c);
      word_t w;
      wlen[c]  = $urandom_range(len_max, len_min);
      fdest[c] = {$urandom, $urandom};
      fsrc[c]  = {$urandom, $urandom};
      if (c == 0) hq0.push_back({fdest[c], fsrc[c]});
      else        hq1.push_back({fdest[c], fsrc[c]});
      for (int i = 0; i < 16; i++) begin
         fdata[c][i] = $urandom;
         fkeep[c][i] = 4'hf;
      end
      fkeep[c][wlen[c]-1] = (keep_last != 0) ? keep_last :
                            4'((1 << $urandom_range(4, 1)) - 1);
      for (int i = 0; i < wlen[c]; i++) begin
         w = '{fdata[c][i], fkeep[c][i], i == wlen[c] - 1};
         if (c == 0) wq0.push_back(w);
         else        wq1.push_back(w);
      end
      busy[c]    = 1;
      hdr_out[c] = 1;
      widx[c]    = 0;
      nfr[c]--;
      gap[c] = $urandom_range(gap_max, 0);
   endtask

   task automatic step();
      bit hsh[2], hsd[2];
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         hsh[c] = s_if.hdr_vld[c] & s_if.hdr_rdy[c];
         hsd[c] = s_if.tvld[c] & s_if.trdy[c];
      end
      hv_cnt = m_if.hdr_vld ? hv_cnt + 1 : 0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         if (busy[c]) begin
            if (hsh[c]) hdr_out[c] = 0;
            if (hsd[c]) widx[c]++;
            if (widx[c] == wlen[c] && !hdr_out[c]) busy[c] = 0;
         end
         if (!busy[c] && nfr[c] > 0) begin
            if (gap[c] > 0) gap[c]--;
            else new_frame(c);
         end
      end
      drive();
   endtask

   task automatic clear_clients();
      for (int c = 0; c < 2; c++) begin
         nfr[c] = 0; widx[c] = 0; wlen[c] = 0; gap[c] = 0;
         busy[c] = 0; hdr_out[c] = 0;
      end
      hq0.delete(); hq1.delete(); wq0.delete(); wq1.delete();
      hv_cnt = 0;
      drive();
   endtask

   task automatic do_reset(input int cyc, input bit all_vld);
      rst_n = 1'b0;
      clear_clients();
      if (all_vld) begin
         s_if.hdr_vld = '1;
         s_if.tvld    = '1;
         s_if.tlast   = '1;
         m_if.hdr_rdy = 1'b1;
         m_if.trdy    = 1'b1;
      end
      repeat (cyc) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_clients();
      glog.delete();
   endtask

   task automatic set_cfg(input int lmin, input int lmax, input int gmax,
                          input int tvp, input int trp, input int hd,
                          input bit e, input logic [3:0] kl);
      len_min = lmin; len_max = lmax; gap_max = gmax;
      tv_pct = tvp; trdy_pct = trp; hdr_delay = hd;
      eager = e; keep_last = kl;
   endtask

   task automatic run_phase(input string name, input int n0, input int n1);
      int cyc = 0;
      nfr[0] = n0;
      nfr[1] = n1;
      while ((nfr[0] > 0 || nfr[1] > 0 || busy[0] || busy[1]) &&
             cyc < 4000) begin
         step();
         cyc++;
      end
      if (cyc >= 4000) begin
         checks++;
         $display("FAIL %s timeout: frames left %0d/%0d", name,
                  nfr[0], nfr[1]);
      end
      repeat (3) step();
      chk({name, " queues drained"},
          hq0.size() + hq1.size() + wq0.size() + wq1.size(), 0);
   endtask

   // pat bit i = expected owner of the i-th granted frame
   task automatic check_order(input string name, input int n,
                              input logic [7:0] pat);
      chk({name, " grant count"}, glog.size(), n);
      for (int i = 0; i < n && i < glog.size(); i++)
         chk({name, " grant order"}, glog[i], 2'b01 << pat[i]);
   endtask

   initial begin : stim
      int cyc;
      set_cfg(1, 8, 0, 100, 100, 0, 1, 4'h0);
      clear_clients();

      // reset with every valid high
      do_reset(10, 1);

      // single client 0, four words, last keep 0011
      set_cfg(4, 4, 0, 100, 100, 0, 1, 4'b0011);
      run_phase("single", 1, 0);
      check_order("single", 1, 8'b0);

      // continuous requests alternate
      do_reset(2, 0);
      set_cfg(1, 6, 0, 100, 100, 0, 1, 4'h0);
      run_phase("rr", 2, 2);
      check_order("rr", 4, 8'b1010);

      // random backpressure, late header ready
      set_cfg(1, 8, 3, 80, 50, 5, 0, 4'h0);
      run_phase("bp", 8, 8);
      set_cfg(1, 8, 2, 70, 60, 0, 0, 4'h0);
      run_phase("rand", 8, 8);

      // single-word frames, header and tlast in one cycle
      do_reset(2, 0);
      set_cfg(1, 1, 0, 100, 100, 0, 1, 4'h0);
      run_phase("sw0", 1, 0);
      run_phase("sw", 1, 1);
      check_order("sw", 3, 8'b010);

      // reset on word 2 of 8 from client 1
      do_reset(2, 0);
      set_cfg(2, 2, 0, 100, 100, 0, 1, 4'h0);
      run_phase("pre", 1, 0);
      set_cfg(8, 8, 0, 100, 100, 0, 1, 4'h0);
      nfr[1] = 1;
      cyc = 0;
      while (!(busy[1] && widx[1] == 2) && cyc < 50) begin
         step();
         cyc++;
      end
      chk("mid-frame word index", widx[1], 2);
      chk("pre-reset m_tvld", m_if.tvld, 1);
      chk("pre-reset grant", grant, 2'b10);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async m_tvld", m_if.tvld, 0);
      chk("async m_hdr_vld", m_if.hdr_vld, 0);
      chk("async grant", grant, 0);
      chk("async s_trdy", s_if.trdy, 0);
      do_reset(3, 0);
      set_cfg(1, 3, 0, 100, 100, 0, 1, 4'h0);
      run_phase("post", 1, 1);
      check_order("post", 2, 8'b10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
